instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
//
// PURPOSE
// - Instruction fetch stage between the processor core and the synchronous program ROM (8-bit address, 8-bit data).
// - Owns the fetch address and drives the ROM address bus. Captures each ROM byte one cycle after its address is issued.
// - Buffers fetched bytes, each tagged with its address, in a small FIFO. The core pops them with a valid/ready handshake.
// - Core jumps flush the buffer and discard any in-flight ROM read.
//
// PARAMETERS
// - ADDR_WIDTH    8      ROM address width; the fetch address wraps modulo 2**ADDR_WIDTH.
// - DATA_WIDTH    8      ROM word / instruction byte width.
// - FIFO_DEPTH    4      Prefetch buffer entries; power of 2, >= 2.
// - RESET_VECTOR  8'h00  Fetch address after reset.
//
// PORTS
// - CLK          in   1             System clock; all state changes on the rising edge.
// - RESET        in   1             Asynchronous, active-high reset.
// - ROM_ADDR     out  ADDR_WIDTH    Address to the ROM; registered (equals the fetch pointer).
// - ROM_DATA     in   DATA_WIDTH    ROM output; valid the cycle after ROM_ADDR was sampled.
// - INSTR_BYTE   out  DATA_WIDTH    Head-of-buffer byte.
// - INSTR_ADDR   out  ADDR_WIDTH    ROM address of INSTR_BYTE.
// - INSTR_VALID  out  1             Buffer non-empty.
// - INSTR_READY  in   1             Core pops the head when INSTR_VALID && INSTR_READY at a clock edge.
// - JUMP         in   1             One-cycle pulse: redirect fetch to JUMP_ADDR.
// - JUMP_ADDR    in   ADDR_WIDTH    Jump target.
// - LEVEL        out  log2(D)+1     Buffer occupancy, 0..FIFO_DEPTH.
//
// BEHAVIOUR
// - Reset (async):
//   - fetch_ptr = ROM_ADDR = RESET_VECTOR; inflight = 0.
//   - INSTR_VALID = 0, INSTR_BYTE = 0, INSTR_ADDR = 0, LEVEL = 0.
//   - Reset mid-operation discards the buffer and any in-flight read.
// - Issue rule: an issue occurs in cycle t when (LEVEL + inflight) < FIFO_DEPTH and JUMP = 0.
//   - Pops in cycle t do not count toward the credit.
//   - On issue: inflight <= 1, inflight_addr <= fetch_ptr, fetch_ptr <= fetch_ptr + 1 (0xFF -> 0x00).
//   - No issue: ROM_ADDR holds. Repeated ROM reads are harmless and never pushed.
// - Capture: when inflight = 1, ROM_DATA is pushed with tag inflight_addr at the end of that cycle.
//   - inflight clears unless a new issue occurs in the same cycle.
//   - Latency: address issued in cycle t gives INSTR_VALID with that byte in cycle t+2.
// - Throughput: sustained 1 byte/cycle while INSTR_READY = 1.
// - Buffer ordering and counting:
//   - Strict address order; no duplicates or gaps except across a jump.
//   - Push and pop in the same cycle leave LEVEL unchanged.
//   - Push when full cannot happen (credit rule); the bench asserts on it.
// - Pop with INSTR_VALID = 0 is ignored.
// - JUMP in cycle t has priority over everything:
//   - Buffer cleared, so LEVEL = 0 and INSTR_VALID = 0 from cycle t+1.
//   - inflight cleared; the ROM_DATA of cycle t is dropped.
//   - A pop in cycle t is ignored. fetch_ptr <= JUMP_ADDR.
//   - JUMP_ADDR is issued in cycle t+1; its byte is INSTR_VALID in cycle t+3.
//   - Back-to-back JUMPs: the last one wins.
// - All outputs are registered except INSTR_BYTE/INSTR_ADDR, which are the FIFO head read.
//
// STRUCTURE
// - Shared package/header holds: ADDR_WIDTH, DATA_WIDTH, RESET_VECTOR, and the ROM read latency constant (1).
//   These are shared with the ROM and the processor.
// - One sub-module: prefetch_fifo.
//   - Synchronous FIFO, width ADDR_WIDTH+DATA_WIDTH, depth FIFO_DEPTH.
//   - Signals: push, pop, flush, count, head.
// - The top level holds fetch_ptr, the inflight flag and tag, the credit logic and the jump priority.
//
// TESTING (ROM model: synchronous, ROM[i] = i ^ 8'h5A)
// - Release RESET, INSTR_READY = 1:
//   -> ROM_ADDR = 0x00 in cycle 0.
//   -> INSTR_VALID first in cycle 2 with BYTE 0x5A / ADDR 0x00.
//   -> Then 0x5B/0x01, 0x58/0x02 on consecutive cycles.
// - INSTR_READY = 0 from reset:
//   -> LEVEL saturates at 4 and ROM_ADDR stops at 0x04.
//   -> On INSTR_READY = 1, ADDR sequence is 00,01,02,03,04,05 with no gap or duplicate.
// - JUMP, JUMP_ADDR = 0x80 in cycle t mid-stream:
//   -> INSTR_VALID = 0 in t+1 and t+2.
//   -> t+3 gives BYTE 0xDA / ADDR 0x80; no pre-jump byte seen after t.
// - JUMP to 0xFE, INSTR_READY = 1:
//   -> ADDR sequence FE, FF, 00, 01 (wrap).
// - Buffer full, INSTR_READY = 1 and JUMP = 1 (JUMP_ADDR = 0x10) in the same cycle:
//   -> pop ignored, LEVEL = 0 next cycle, first byte ADDR 0x10.
// - RESET asserted for 1 cycle while inflight = 1 and LEVEL = 3:
//   -> outputs clear without waiting for a clock edge.
//   -> Restart at ADDR 0x00 with latency 2.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: widths, reset vector and ROM timing shared by the ROM, the prefetch stage and the core.
package instr_prefetch_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 8'h00;
    localparam int ROM_LATENCY = 1;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of address-tagged instruction bytes with flush; head reads as zero when empty.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
    assign head = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetch stage driving the program ROM, buffering tagged bytes for the core, flushed by jumps.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [DATA_WIDTH-1:0]         instr_byte,
    output logic [ADDR_WIDTH-1:0]         instr_addr,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    input  logic                          jump,
    input  logic [ADDR_WIDTH-1:0]         jump_addr,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [ADDR_WIDTH-1:0] fetch_ptr, inflight_addr;
    logic inflight, issue, push, pop;
    fetch_entry_t din, head;
    // the in-flight read reserves a slot so a capture can never find the buffer full
    assign issue = !jump && (level + LW'(inflight)) < LW'(FIFO_DEPTH);
    assign push = inflight && !jump;
    assign pop = instr_valid && instr_ready && !jump;
    assign instr_valid = level != '0;
    assign rom_addr = fetch_ptr;
    assign din = {inflight_addr, rom_data};
    assign instr_byte = head.data;
    assign instr_addr = head.addr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_ptr     <= RESET_VECTOR;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (jump) begin
            fetch_ptr <= jump_addr;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= fetch_ptr;
                fetch_ptr     <= fetch_ptr + ADDR_WIDTH'(1);
            end
        end
    end
    prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (jump),
        .din   (din),
        .head  (head),
        .count (level)
    );
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed vector table plus hand sequences for stall, jump and async reset behaviour.
module tb_instr_prefetch;
    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] rom_addr, rom_data, instr_byte, instr_addr, jump_addr;
    logic instr_valid, instr_ready, jump;
    logic [2:0] level;
    int checks = 0, failures = 0;

    typedef struct {
        logic ready; logic jmp; logic [7:0] jaddr;
        logic ev; logic [7:0] eb; logic [7:0] ea; logic [2:0] el; logic [7:0] er;
    } vec_t;
    vec_t v[26];

    instr_prefetch dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_byte(instr_byte), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr), .level(level)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_data <= rom_addr ^ 8'h5A;

    always @(negedge clk) begin
        if (!reset && dut.push && level == 3'd4) begin
            failures++;
            $display("FAIL push_when_full: level=%0d push=1 required no push", level);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic j, input logic [7:0] ja, input logic ev,
                                input logic [7:0] eb, input logic [7:0] ea, input logic [2:0] el, input logic [7:0] er);
        vec_t x;
        x.ready = r; x.jmp = j; x.jaddr = ja; x.ev = ev; x.eb = eb; x.ea = ea; x.el = el; x.er = er;
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] seen[$];
        instr_ready = 1'b0; jump = 1'b0; jump_addr = 8'h00;
        v[0]  = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h00);
        v[1]  = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h01);
        v[2]  = mk(1,0,8'h00, 1,8'h5A,8'h00,1,8'h02);
        v[3]  = mk(1,0,8'h00, 1,8'h5B,8'h01,1,8'h03);
        v[4]  = mk(1,0,8'h00, 1,8'h58,8'h02,1,8'h04);
        v[5]  = mk(1,0,8'h00, 1,8'h59,8'h03,1,8'h05);
        v[6]  = mk(1,1,8'h80, 1,8'h5E,8'h04,1,8'h06);
        v[7]  = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h80);
        v[8]  = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h81);
        v[9]  = mk(1,0,8'h00, 1,8'hDA,8'h80,1,8'h82);
        v[10] = mk(1,0,8'h00, 1,8'hDB,8'h81,1,8'h83);
        v[11] = mk(1,1,8'hFE, 1,8'hD8,8'h82,1,8'h84);
        v[12] = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'hFE);
        v[13] = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'hFF);
        v[14] = mk(1,0,8'h00, 1,8'hA4,8'hFE,1,8'h00);
        v[15] = mk(1,0,8'h00, 1,8'hA5,8'hFF,1,8'h01);
        v[16] = mk(1,0,8'h00, 1,8'h5A,8'h00,1,8'h02);
        v[17] = mk(1,0,8'h00, 1,8'h5B,8'h01,1,8'h03);
        v[18] = mk(0,0,8'h00, 1,8'h58,8'h02,1,8'h04);
        v[19] = mk(0,0,8'h00, 1,8'h58,8'h02,2,8'h05);
        v[20] = mk(0,0,8'h00, 1,8'h58,8'h02,3,8'h06);
        v[21] = mk(0,0,8'h00, 1,8'h58,8'h02,4,8'h06);
        v[22] = mk(1,1,8'h10, 1,8'h58,8'h02,4,8'h06);
        v[23] = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h10);
        v[24] = mk(1,0,8'h00, 0,8'h00,8'h00,0,8'h11);
        v[25] = mk(1,0,8'h00, 1,8'h4A,8'h10,1,8'h12);

        // reset state while reset is held
        #12;
        chk("reset_valid", 32'(instr_valid), 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        chk("reset_byte", 32'(instr_byte), 0);
        chk("reset_addr", 32'(instr_addr), 0);

        // stream, jump to 0x80, jump to 0xFE with wrap, fill, jump+pop while full
        do_reset();
        for (int i = 0; i < 26; i++) begin
            instr_ready = v[i].ready; jump = v[i].jmp; jump_addr = v[i].jaddr;
            @(negedge clk);
            chk($sformatf("c%0d_valid", i), 32'(instr_valid), 32'(v[i].ev));
            chk($sformatf("c%0d_level", i), 32'(level), 32'(v[i].el));
            chk($sformatf("c%0d_rom_addr", i), 32'(rom_addr), 32'(v[i].er));
            if (v[i].ev) begin
                chk($sformatf("c%0d_byte", i), 32'(instr_byte), 32'(v[i].eb));
                chk($sformatf("c%0d_addr", i), 32'(instr_addr), 32'(v[i].ea));
            end
            @(posedge clk); #1;
        end
        jump = 1'b0;

        // stalled from reset: saturate, then drain in order without gaps
        do_reset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("stall_level", 32'(level), 4);
        chk("stall_rom_addr", 32'(rom_addr), 8'h04);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        for (int i = 0; i < 12 && seen.size() < 6; i++) begin
            @(negedge clk);
            if (instr_valid) seen.push_back(instr_addr);
            @(posedge clk); #1;
        end
        chk("drain_count", 32'(seen.size()), 6);
        for (int i = 0; i < seen.size(); i++)
            chk($sformatf("drain_addr%0d", i), 32'(seen[i]), 32'(i));

        // async reset with a read in flight and three bytes buffered
        do_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_level", 32'(level), 3);
        chk("pre_reset_inflight", 32'(dut.inflight), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 0);
        chk("async_level", 32'(level), 0);
        chk("async_rom_addr", 32'(rom_addr), 0);
        @(posedge clk); #1 reset = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("restart_c%0d_valid", i), 32'(instr_valid), 32'(i == 2));
            if (i == 2) begin
                chk("restart_byte", 32'(instr_byte), 8'h5A);
                chk("restart_addr", 32'(instr_addr), 8'h00);
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
